divide: RTL and testbench
=========================

# divide

Sequential restoring divider, the inverse of the project's `multiply` block. It takes a double-width dividend, which is the width `multiply` produces, and a single-width divisor. It returns a double-width quotient and a single-width remainder, resolving one quotient bit per clock behind a valid/ready handshake. It sits beside `multiply` in the matrix datapath for normalisation and for inverting a product.

## Interface
Parameters:
- `INPUTSIZE`, default 16: maximum operand magnitude, same meaning as in `multiply`.
- `INWIDTH`, localparam `$clog2(INPUTSIZE)`: divisor and remainder width (4 at default).
- `OUTWIDTH`, localparam `INWIDTH*2`: dividend and quotient width (8 at default).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: dividend and divisor are valid.
- `in_ready`  out  1: block can accept operands.
- `dividend`  in  OUTWIDTH: numerator, unsigned.
- `divisor`  in  INWIDTH: denominator, unsigned.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `quotient`  out  OUTWIDTH: floor(dividend/divisor).
- `remainder`  out  INWIDTH: dividend mod divisor.
- `div_by_zero`  out  1: qualifies the current result; the divisor was 0.

## Operation
- State machine `div_state_t`: DIV_IDLE, DIV_CALC, DIV_DONE.
- **DIV_IDLE:** `in_ready`=1. On `in_valid`:
  - Latch the dividend into the quotient/shift register.
  - Latch the divisor.
  - Clear the partial remainder (INWIDTH+1 bits).
  - Load the bit counter with OUTWIDTH-1.
  - If divisor==0, go to DIV_DONE. Otherwise go to DIV_CALC.
- **DIV_CALC:** `in_ready`=0. One restoring step per cycle, MSB first:
  - Form `pr = {rem[INWIDTH-1:0], q[OUTWIDTH-1]}` and shift `q` left.
  - If `pr >= divisor`: `rem = pr - divisor` and `q[0]=1`.
  - Else: `rem = pr` and `q[0]=0`.
  - When the counter reaches 0, go to DIV_DONE. Otherwise decrement the counter.
- **DIV_DONE:** `out_valid`=1 and outputs are held stable. On `out_ready`, go to DIV_IDLE.
- **Divide-by-zero:**
  - `quotient` = all ones.
  - `remainder` = `dividend[INWIDTH-1:0]`.
  - `div_by_zero`=1.
- Arithmetic is unsigned only. The partial remainder never exceeds 2*divisor-1, so INWIDTH+1 bits suffice. The final remainder fits in INWIDTH bits.
- `in_valid` is ignored outside DIV_IDLE. Operands are not re-sampled during DIV_CALC.

## Timing
- Reset values:
  - State DIV_IDLE, so `in_ready`=1 and `out_valid`=0.
  - `quotient`, `remainder` and `div_by_zero` all 0.
  - Counter 0.
- Accept on edge E0 (`in_valid & in_ready`). Iterations run on edges E0+1 through E0+OUTWIDTH, and `out_valid` rises after edge E0+OUTWIDTH. Latency is 8 cycles at default.
- Divide-by-zero: `out_valid` rises after edge E0+1 (latency 1).
- Result retire on edge R (`out_valid & out_ready`): `in_ready` is high after R. The next accept is no earlier than edge R+1, so there is no same-cycle accept-on-retire. Throughput is one result per OUTWIDTH+2 cycles when `out_ready` is held high.
- Backpressure: `out_ready` low holds DIV_DONE indefinitely with outputs unchanged.
- Reset asserted mid-DIV_CALC or in DIV_DONE aborts immediately to reset values. The in-flight result is discarded and never presented.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Add to `mm_defs`:
  - `typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t`.
  - Constant `DIV_ZERO_QUOTIENT` (all ones) for the divide-by-zero quotient.
- Sub-module `divide_step`: purely combinational single restoring step. Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder, quotient bit.
- `divide` holds the FSM, counter and shift registers and instantiates one `divide_step`.

## Test plan
All at default parameters (INWIDTH=4, OUTWIDTH=8).
- **Basic:** dividend=200, divisor=7 -> quotient=28, remainder=4, div_by_zero=0. `out_valid` high exactly 8 cycles after accept.
- **Inverse of multiply:** dividend=143 (13*11), divisor=11 -> quotient=13, remainder=0. Sweep all A,B in 1..15 through `multiply`, then `divide`, and check the quotient returns A.
- **Extremes:**
  - 255/1 -> quotient=255, remainder=0.
  - 255/15 -> quotient=17, remainder=0.
  - 0/9 -> quotient=0, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
- **Divide-by-zero:** dividend=8'hA6, divisor=0 -> quotient=8'hFF, remainder=4'h6, div_by_zero=1, `out_valid` after 1 cycle.
- **Backpressure and back-to-back:**
  - Hold `out_ready`=0 for 10 cycles: outputs stay stable, `in_ready`=0, and a new `in_valid` is ignored.
  - Then drive `out_ready`=1: `in_ready` rises the next cycle and the second operation completes correctly.
- **Reset mid-op:** assert `rst` 3 cycles into DIV_CALC -> `out_valid`=0 immediately and all outputs are 0. After deassert, a fresh 200/7 yields 28 r 4.

Source files
------------

// File: rtl/mm_defs_pkg.sv
// Shared matrix-datapath definitions: divider state encoding and the
// quotient reported when the divisor is zero.
package mm_defs;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Wider than any practical quotient; users slice the low OUTWIDTH bits.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/divide_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divide_step #(
  parameter int INWIDTH = 4
) (
  input  logic [INWIDTH-1:0] rem_in,
  input  logic               bit_in,
  input  logic [INWIDTH-1:0] divisor,
  output logic [INWIDTH-1:0] rem_out,
  output logic               q_bit
);

  logic [INWIDTH:0] pr;
  logic             fits;

  always_comb begin
    pr   = {rem_in, bit_in};
    fits = (pr >= {1'b0, divisor});
    // The result is always below the divisor, so INWIDTH bits hold it.
    rem_out = fits ? INWIDTH'(pr - {1'b0, divisor}) : INWIDTH'(pr);
    q_bit   = fits;
  end

endmodule

// File: rtl/divide.sv
// Sequential restoring divider: double-width dividend by single-width divisor,
// one quotient bit per clock behind valid/ready handshakes.
module divide
  import mm_defs::*;
#(
  parameter  int INPUTSIZE = 16,
  localparam int INWIDTH   = $clog2(INPUTSIZE),
  localparam int OUTWIDTH  = INWIDTH * 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUTWIDTH-1:0] dividend,
  input  logic [INWIDTH-1:0]  divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTWIDTH-1:0] quotient,
  output logic [INWIDTH-1:0]  remainder,
  output logic                div_by_zero,
  output div_state_t          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload until that edge, ready never waits on valid.

  localparam int CNTW = (OUTWIDTH > 2) ? $clog2(OUTWIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(OUTWIDTH - 1);

  div_state_t          state_q, state_d;
  logic [OUTWIDTH-1:0] q_q, q_d;
  logic [INWIDTH-1:0]  rem_q, rem_d;
  logic [INWIDTH-1:0]  dvs_q, dvs_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [OUTWIDTH-1:0] quo_q, quo_d;
  logic [INWIDTH-1:0]  remo_q, remo_d;
  logic                dbz_q, dbz_d;
  logic                ov_q, ov_d;

  logic [INWIDTH-1:0]  step_rem;
  logic                step_qbit;

  divide_step #(.INWIDTH(INWIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (q_q[OUTWIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ov_d    = ov_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          q_d   = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = CNT_LOAD;
          if (divisor == '0) begin
            state_d = DIV_DONE;
            quo_d   = DIV_ZERO_QUOTIENT[OUTWIDTH-1:0];
            remo_d  = dividend[INWIDTH-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        q_d   = {q_q[OUTWIDTH-2:0], step_qbit};
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
          ov_d    = 1'b1;
          quo_d   = {q_q[OUTWIDTH-2:0], step_qbit};
          remo_d  = step_rem;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV_DONE: begin
        // Divide-by-zero enters here with valid still low; raise it one cycle later.
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign in_ready    = (state_q == DIV_IDLE);
  assign out_valid   = ov_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_divide.sv
// Directed and randomized checks of the divider against an arithmetic model.
module tb_divide;
  import mm_defs::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  div_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {div_by_zero, remainder, quotient}.
  logic [12:0] exp_q[$];

  divide #(.INPUTSIZE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division, with the zero-divisor convention.
  function automatic logic [12:0] model(input int dd, input int dv);
    int q, r;
    if (dv == 0) begin
      q = 255;
      r = dd % 16;
      return {1'b1, 4'(r), 8'(q)};
    end
    q = dd / dv;
    r = dd % dv;
    return {1'b0, 4'(r), 8'(q)};
  endfunction

  task automatic accept(input logic [7:0] dd, input logic [3:0] dv);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    exp_q.push_back(model(int'(dd), int'(dv)));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check("out_valid_timeout", (n < 40), 1);
  endtask

  task automatic compare_result(input string tag);
    logic [12:0] e;
    e = exp_q.pop_front();
    check({tag, "_quotient"}, quotient, e[7:0]);
    check({tag, "_remainder"}, remainder, e[11:8]);
    check({tag, "_dbz"}, div_by_zero, e[12]);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("retire_out_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                        input bit chk_lat);
    int n;
    accept(dd, dv);
    wait_valid(n);
    if (chk_lat) check({tag, "_latency"}, n, (dv == 0) ? 1 : 8);
    compare_result(tag);
    retire();
  endtask

  initial begin
    int n;
    logic [12:0] e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;

    // Directed cases
    run_op("basic_200_7", 8'd200, 4'd7, 1'b1);
    run_op("inv_143_11", 8'd143, 4'd11, 1'b1);
    run_op("ext_255_1", 8'd255, 4'd1, 1'b1);
    run_op("ext_255_15", 8'd255, 4'd15, 1'b1);
    run_op("ext_0_9", 8'd0, 4'd9, 1'b1);
    run_op("ext_5_9", 8'd5, 4'd9, 1'b1);
    run_op("dbz_a6", 8'hA6, 4'd0, 1'b1);

    // Inverse of multiply: (A*B)/B must return A.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        accept(8'(a * b), 4'(b));
        wait_valid(n);
        check("inverse_quotient_is_a", quotient, a);
        compare_result("inverse");
        retire();
      end
    end

    // Randomized operands, including zero divisors.
    for (int i = 0; i < 60; i++) begin
      run_op("random", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1);
    end

    // Backpressure: hold the result, ignore a new request, then retire.
    accept(8'd200, 4'd7);
    wait_valid(n);
    e = exp_q.pop_front();
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", {div_by_zero, remainder, quotient}, e);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    retire();
    run_op("after_bp_99_3", 8'd99, 4'd3, 1'b1);

    // Reset three cycles into the calculation.
    accept(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_200_7", 8'd200, 4'd7, 1'b1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
